// File: rtl/conv_pkg.sv
// Shared encodings and kernel coefficient tables for the 3x3 streaming filter.
package conv_pkg;

  // Kernel selector, latched when a frame starts.
  typedef enum logic [1:0] {
    KM_IDENTITY = 2'd0,
    KM_BLUR     = 2'd1,
    KM_SHARPEN  = 2'd2,
    KM_EDGE     = 2'd3
  } kernel_mode_t;

  // Frame control states.
  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    RUN     = 2'd1,
    FLUSH   = 2'd2,
    DONE_ST = 2'd3
  } state_t;

  // Blur weights sum to 16; the normalising shift stays fixed at borders.
  localparam int BLUR_SHIFT = 4;

  localparam int COEF_W = 4;
  typedef logic signed [COEF_W-1:0] coef_t;

  // Row-major taps, top row first, indexed by kernel_mode_t.
  localparam coef_t KERNELS [4][9] = '{
    '{ 4'sd0,  4'sd0,  4'sd0,  4'sd0,  4'sd1,  4'sd0,  4'sd0,  4'sd0,  4'sd0},
    '{ 4'sd1,  4'sd2,  4'sd1,  4'sd2,  4'sd4,  4'sd2,  4'sd1,  4'sd2,  4'sd1},
    '{ 4'sd0, -4'sd1,  4'sd0, -4'sd1,  4'sd5, -4'sd1,  4'sd0, -4'sd1,  4'sd0},
    '{-4'sd1, -4'sd1, -4'sd1,  4'sd0,  4'sd0,  4'sd0,  4'sd1,  4'sd1,  4'sd1}
  };

  // Coefficient lookup; idx = row*3 + col within the 3x3 window.
  function automatic coef_t kernel_coef(input kernel_mode_t mode, input logic [3:0] idx);
    return KERNELS[mode][idx];
  endfunction

endpackage

// File: rtl/line_buffer.sv
// One row of pixels: WIDTH-deep RAM, one read and one write per step,
// read returns the old contents when reading and writing the same address.
module line_buffer #(
  parameter int WIDTH  = 788,
  parameter int DATA_W = 24
) (
  input  logic                     clk,
  input  logic                     i_we,
  input  logic [$clog2(WIDTH)-1:0] i_addr,
  input  logic [DATA_W-1:0]        i_wdata,
  output logic [DATA_W-1:0]        o_rdata
);

  logic [DATA_W-1:0] r_mem [WIDTH];

  // Combinational read sees the value before this step's write lands.
  assign o_rdata = r_mem[i_addr];

  // Write port.
  // NOTE: the array has no reset; its contents are masked by the row counter until written.
  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (i_we) r_mem[i_addr] <= i_wdata;
  end

endmodule

// File: rtl/conv3x3_stream.sv
// Streaming 3x3 convolution over packed multi-channel pixels using two line
// buffers. Output pixel k is produced on step k+WIDTH+1; the last WIDTH+1
// steps run without input and feed zeros for the row below the frame.
module conv3x3_stream
  import conv_pkg::*;
#(
  parameter int WIDTH    = 788,
  parameter int HEIGHT   = 1080,
  parameter int CHANNELS = 3,
  parameter int PIX_W    = 8
) (
  input  logic                      clk,
  input  logic                      reset_n,
  input  logic                      start,
  input  logic [1:0]                kernel_mode,
  input  logic                      in_valid,
  output logic                      in_ready,
  input  logic [CHANNELS*PIX_W-1:0] in_data,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic [CHANNELS*PIX_W-1:0] out_data,
  output logic                      out_last,
  output logic                      busy,
  output logic                      frame_done
);

  localparam int PX_W        = CHANNELS * PIX_W;
  localparam int ACC_W       = PIX_W + 6;
  localparam int FRAME_PIX   = HEIGHT * WIDTH;
  localparam int TOTAL_STEPS = FRAME_PIX + WIDTH + 1;
  localparam int K_W         = $clog2(TOTAL_STEPS + 1);
  localparam int COL_W       = $clog2(WIDTH);
  localparam int ROW_W       = $clog2(HEIGHT + 2);

  // One window column: [0] top row, [1] middle, [2] bottom.
  typedef logic [2:0][PX_W-1:0] col_t;

  state_t             r_state;
  kernel_mode_t       r_mode;
  logic [K_W-1:0]     r_step;
  logic [COL_W-1:0]   r_col;
  logic [ROW_W-1:0]   r_row;
  col_t               r_win_l;
  col_t               r_win_m;
  logic               r_out_valid;
  logic [PX_W-1:0]    r_out_data;
  logic               r_out_last;
  logic               r_busy;
  logic               r_frame_done;

  logic               w_out_free;
  logic               w_step;
  logic               w_emit;
  logic               w_last_step;
  logic [PX_W-1:0]    w_rd0;
  logic [PX_W-1:0]    w_rd1;
  col_t               w_new_col;
  col_t               w_win [3];
  logic signed [ACC_W-1:0] w_acc [CHANNELS];
  logic [PX_W-1:0]    w_result;

  assign w_out_free  = !r_out_valid || out_ready;
  assign in_ready    = (r_state == RUN) && w_out_free;
  assign w_step      = (r_state == RUN)   ? (in_valid && w_out_free) :
                       (r_state == FLUSH) ? (w_out_free && (r_step != K_W'(TOTAL_STEPS))) :
                       1'b0;
  assign w_emit      = (r_step >= K_W'(WIDTH + 1));
  assign w_last_step = (r_step == K_W'(TOTAL_STEPS - 1));

  // lb0 holds the previous row, lb1 the row before it; lb1 is refilled from lb0's old data.
  line_buffer #(.WIDTH(WIDTH), .DATA_W(PX_W)) u_lb0 (
    .clk     (clk),
    .i_we    (w_step && (r_state == RUN)),
    .i_addr  (r_col),
    .i_wdata (in_data),
    .o_rdata (w_rd0)
  );

  line_buffer #(.WIDTH(WIDTH), .DATA_W(PX_W)) u_lb1 (
    .clk     (clk),
    .i_we    (w_step && (r_state == RUN)),
    .i_addr  (r_col),
    .i_wdata (w_rd0),
    .o_rdata (w_rd1)
  );

  // Incoming column with rows above the frame forced to zero; the row below
  // the frame is zero because no input is taken while flushing.
  assign w_new_col[0] = (r_row >= ROW_W'(2)) ? w_rd1 : '0;
  assign w_new_col[1] = (r_row >= ROW_W'(1)) ? w_rd0 : '0;
  assign w_new_col[2] = (r_state == RUN) ? in_data : '0;

  // At column 0 the window belongs to the last pixel of the previous row, so
  // its right column is padding rather than the new column (no wrap-around).
  assign w_win[0] = r_win_l;
  assign w_win[1] = r_win_m;
  assign w_win[2] = (r_col == '0) ? col_t'('0) : w_new_col;

  // Per-channel multiply-accumulate, blur normalisation and saturation.
  // NOTE: every combinational output gets a default first so no latch is inferred.
  always_comb begin
    w_result = '0;
    for (int ch = 0; ch < CHANNELS; ch++) begin
      w_acc[ch] = '0;
      for (int tr = 0; tr < 3; tr++) begin
        for (int tc = 0; tc < 3; tc++) begin
          w_acc[ch] = w_acc[ch] +
                      ACC_W'(kernel_coef(r_mode, 4'(tr * 3 + tc))) *
                      $signed({{(ACC_W-PIX_W){1'b0}}, w_win[tc][tr][ch*PIX_W +: PIX_W]});
        end
      end
      if (r_mode == KM_BLUR) w_acc[ch] = w_acc[ch] >>> BLUR_SHIFT;
      if (w_acc[ch][ACC_W-1])
        w_result[ch*PIX_W +: PIX_W] = '0;
      else if (w_acc[ch] > ACC_W'((2 ** PIX_W) - 1))
        w_result[ch*PIX_W +: PIX_W] = '1;
      else
        w_result[ch*PIX_W +: PIX_W] = w_acc[ch][PIX_W-1:0];
    end
  end

  // Frame control FSM with registered busy / frame_done.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state      <= IDLE;
      r_mode       <= KM_IDENTITY;
      r_busy       <= 1'b0;
      r_frame_done <= 1'b0;
    end else begin
      r_frame_done <= 1'b0;
      case (r_state)
        IDLE: begin
          if (start) begin
            r_state <= RUN;
            r_busy  <= 1'b1;
            r_mode  <= kernel_mode_t'(kernel_mode);
          end
        end
        RUN: begin
          if (w_step && (r_step == K_W'(FRAME_PIX - 1))) r_state <= FLUSH;
        end
        FLUSH: begin
          if (r_out_valid && out_ready && r_out_last) begin
            r_state      <= DONE_ST;
            r_busy       <= 1'b0;
            r_frame_done <= 1'b1;
          end
        end
        DONE_ST: r_state <= IDLE;
        default: r_state <= IDLE;
      endcase
    end
  end

  // Raster position, step count and window column shift register.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_step  <= '0;
      r_col   <= '0;
      r_row   <= '0;
      r_win_l <= '0;
      r_win_m <= '0;
    end else if ((r_state == IDLE) && start) begin
      r_step  <= '0;
      r_col   <= '0;
      r_row   <= '0;
      r_win_l <= '0;
      r_win_m <= '0;
    end else if (w_step) begin
      r_step <= r_step + K_W'(1);
      if (r_col == COL_W'(WIDTH - 1)) begin
        r_col <= '0;
        r_row <= r_row + ROW_W'(1);
      end else begin
        r_col <= r_col + COL_W'(1);
      end
      r_win_l <= (r_col == '0) ? col_t'('0) : r_win_m;
      r_win_m <= w_new_col;
    end
  end

  // Single-entry output register; holds while the sink stalls.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_out_valid <= 1'b0;
      r_out_data  <= '0;
      r_out_last  <= 1'b0;
    end else if (w_step && w_emit) begin
      r_out_valid <= 1'b1;
      r_out_data  <= w_result;
      r_out_last  <= w_last_step;
    end else if (out_ready) begin
      r_out_valid <= 1'b0;
      r_out_last  <= 1'b0;
    end
  end

  assign out_valid  = r_out_valid;
  assign out_data   = r_out_data;
  assign out_last   = r_out_last;
  assign busy       = r_busy;
  assign frame_done = r_frame_done;

endmodule

// File: tb/tb_conv3x3_stream.sv
// Directed bench for conv3x3_stream on a 4x3 frame: expected pixels are
// queued per frame and popped on each output handshake.
module tb_conv3x3_stream;

  localparam int W      = 4;
  localparam int H      = 3;
  localparam int NPIX   = W * H;
  localparam int BUDGET = 1000;

  // Reference kernels, row-major, top row first.
  localparam int KT [4][9] = '{
    '{ 0,  0,  0,  0, 1,  0, 0,  0, 0},
    '{ 1,  2,  1,  2, 4,  2, 1,  2, 1},
    '{ 0, -1,  0, -1, 5, -1, 0, -1, 0},
    '{-1, -1, -1,  0, 0,  0, 1,  1, 1}
  };

  typedef struct packed {
    logic        last;
    logic [23:0] data;
  } exp_t;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        start;
  logic [1:0]  kernel_mode;
  logic        in_valid;
  logic        in_ready;
  logic [23:0] in_data;
  logic        out_valid;
  logic        out_ready;
  logic [23:0] out_data;
  logic        out_last;
  logic        busy;
  logic        frame_done;

  logic [23:0] frame [H][W];
  exp_t        exp_q [$];
  int          n_checks = 0;
  int          n_fail   = 0;

  always #5 clk = ~clk;

  conv3x3_stream #(.WIDTH(W), .HEIGHT(H), .CHANNELS(3), .PIX_W(8)) dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .start       (start),
    .kernel_mode (kernel_mode),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .in_data     (in_data),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .out_data    (out_data),
    .out_last    (out_last),
    .busy        (busy),
    .frame_done  (frame_done)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_checks++;
    assert (obs === expv) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  // Direct zero-padded 3x3 convolution of the stored frame.
  function automatic logic [23:0] ref_pix(input int mode, input int r, input int c);
    logic [23:0] res;
    int acc, rr, cc;
    res = '0;
    for (int ch = 0; ch < 3; ch++) begin
      acc = 0;
      for (int dr = -1; dr <= 1; dr++) begin
        for (int dc = -1; dc <= 1; dc++) begin
          rr = r + dr;
          cc = c + dc;
          if (rr >= 0 && rr < H && cc >= 0 && cc < W)
            acc += KT[mode][(dr + 1) * 3 + (dc + 1)] * int'(frame[rr][cc][ch*8 +: 8]);
        end
      end
      if (mode == 1) acc = acc >>> 4;
      if (acc < 0) acc = 0;
      else if (acc > 255) acc = 255;
      res[ch*8 +: 8] = 8'(acc);
    end
    return res;
  endfunction

  // Corner / edge / interior classification for uniform-input frames.
  function automatic logic [23:0] region_val(input int r, input int c,
                                             input int corner, input int border, input int inner);
    bit er, ec;
    int v;
    er = (r == 0) || (r == H - 1);
    ec = (c == 0) || (c == W - 1);
    v  = (er && ec) ? corner : (er || ec) ? border : inner;
    return {3{8'(v)}};
  endfunction

  task automatic push_exp(input logic [23:0] d, input int idx);
    exp_t e;
    e.last = (idx == NPIX - 1);
    e.data = d;
    exp_q.push_back(e);
  endtask

  task automatic fill_const(input logic [7:0] v);
    for (int r = 0; r < H; r++)
      for (int c = 0; c < W; c++) frame[r][c] = {3{v}};
  endtask

  task automatic load_ramp();
    for (int i = 0; i < NPIX; i++) begin
      frame[i / W][i % W] = {3{8'(i)}};
      push_exp({3{8'(i)}}, i);
    end
  endtask

  task automatic run_frame(input logic [1:0] mode, input bit bp, input bit chk_lat);
    int acc_n, out_n, cyc, acc6_cyc, first_ov;
    bit held_v;
    logic [23:0] held_d;
    logic held_l;
    exp_t e;
    acc_n = 0; out_n = 0; cyc = 0; acc6_cyc = -1; first_ov = -1;
    held_v = 1'b0; held_d = '0; held_l = 1'b0;
    @(negedge clk);
    start = 1'b1;
    kernel_mode = mode;
    @(negedge clk);
    start = 1'b0;
    kernel_mode = ~mode;
    #1 check("busy_after_start", 32'(busy), 1);
    while (out_n < NPIX && cyc < BUDGET) begin
      @(negedge clk);
      in_valid  = (acc_n < NPIX) && (!bp || ($urandom_range(0, 9) < 7));
      in_data   = (acc_n < NPIX) ? frame[acc_n / W][acc_n % W] : 24'($urandom);
      out_ready = !bp || ($urandom_range(0, 1) == 1);
      start     = (cyc == 10);
      #1;
      if (held_v) begin
        check("hold_valid", 32'(out_valid), 1);
        check("hold_data", 32'(out_data), 32'(held_d));
        check("hold_last", 32'(out_last), 32'(held_l));
      end
      held_v = out_valid && !out_ready;
      if (held_v) begin
        held_d = out_data;
        held_l = out_last;
        check("in_ready_while_held", 32'(in_ready), 0);
      end
      if (out_valid && first_ov < 0) first_ov = cyc;
      if (out_valid && out_ready) begin
        e = exp_q.pop_front();
        check("out_data", 32'(out_data), 32'(e.data));
        check("out_last", 32'(out_last), 32'(e.last));
        out_n++;
      end
      if (in_valid && in_ready) begin
        acc_n++;
        if (acc_n == W + 2) acc6_cyc = cyc;
      end
      cyc++;
    end
    start = 1'b0;
    check("frame_outputs", out_n, NPIX);
    if (chk_lat) check("first_valid_latency", first_ov - acc6_cyc, 1);
    @(negedge clk);
    in_valid  = 1'b0;
    out_ready = 1'b1;
    #1;
    check("frame_done_pulse", 32'(frame_done), 1);
    check("busy_clear", 32'(busy), 0);
    check("no_extra_output", 32'(out_valid), 0);
    @(negedge clk);
    #1 check("frame_done_low", 32'(frame_done), 0);
    exp_q.delete();
  endtask

  initial begin
    int acc, cyc;
    reset_n     = 1'b0;
    start       = 1'b0;
    kernel_mode = 2'd0;
    in_valid    = 1'b0;
    in_data     = '0;
    out_ready   = 1'b1;

    // Reset state
    repeat (3) @(negedge clk);
    #1;
    check("rst_in_ready", 32'(in_ready), 0);
    check("rst_out_valid", 32'(out_valid), 0);
    check("rst_out_data", 32'(out_data), 0);
    check("rst_out_last", 32'(out_last), 0);
    check("rst_busy", 32'(busy), 0);
    check("rst_frame_done", 32'(frame_done), 0);
    @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);

    // IDENTITY ramp with latency check
    load_ramp();
    run_frame(2'd0, 1'b0, 1'b1);

    // BLUR constant 160
    fill_const(8'd160);
    for (int i = 0; i < NPIX; i++) push_exp(region_val(i / W, i % W, 90, 120, 160), i);
    run_frame(2'd1, 1'b0, 1'b0);

    // SHARPEN constant 100
    fill_const(8'd100);
    for (int i = 0; i < NPIX; i++) push_exp(region_val(i / W, i % W, 255, 200, 100), i);
    run_frame(2'd2, 1'b0, 1'b0);

    // EDGE with rows 10/20/30
    for (int r = 0; r < H; r++)
      for (int c = 0; c < W; c++) frame[r][c] = {3{8'(10 * (r + 1))}};
    for (int i = 0; i < NPIX; i++) begin
      if (i / W == 2)                    push_exp(24'd0, i);
      else if (i % W == 0 || i % W == W - 1) push_exp({3{8'd40}}, i);
      else                               push_exp({3{8'd60}}, i);
    end
    run_frame(2'd3, 1'b0, 1'b0);

    // BLUR random frame, free flowing then with backpressure
    for (int r = 0; r < H; r++)
      for (int c = 0; c < W; c++) frame[r][c] = 24'($urandom);
    for (int i = 0; i < NPIX; i++) push_exp(ref_pix(1, i / W, i % W), i);
    run_frame(2'd1, 1'b0, 1'b0);
    for (int i = 0; i < NPIX; i++) push_exp(ref_pix(1, i / W, i % W), i);
    run_frame(2'd1, 1'b1, 1'b0);

    // Reset after 5 accepts, then a clean IDENTITY frame
    for (int i = 0; i < NPIX; i++) frame[i / W][i % W] = {3{8'(i)}};
    @(negedge clk);
    start = 1'b1;
    kernel_mode = 2'd0;
    @(negedge clk);
    start = 1'b0;
    in_valid = 1'b1;
    out_ready = 1'b1;
    acc = 0;
    cyc = 0;
    while (acc < 5 && cyc < 100) begin
      in_data = frame[acc / W][acc % W];
      #1;
      if (in_ready) acc++;
      cyc++;
      @(negedge clk);
    end
    check("accepts_before_reset", acc, 5);
    reset_n  = 1'b0;
    in_valid = 1'b0;
    #1;
    check("midrst_out_valid", 32'(out_valid), 0);
    check("midrst_in_ready", 32'(in_ready), 0);
    check("midrst_busy", 32'(busy), 0);
    @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);
    load_ramp();
    run_frame(2'd0, 1'b0, 1'b1);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
